// File: rtl/debounce_multi.sv
// N-channel push-button conditioner: per channel a 2-FF synchroniser, saturating
// integrator, hysteretic level FSM, press/release/long-press pulses; plus any_change.

module debounce_ch #(
    parameter int CNT_W       = 20,
    parameter int MAX_COUNT   = 1048575,
    parameter int ON_TH       = 1000000,
    parameter int OFF_TH      = 500000,
    parameter int HOLD_CYCLES = 50000000,
    parameter int HOLD_W      = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press,
    output logic released,
    output logic long_press,
    output logic change_nxt
);
    localparam logic [CNT_W-1:0]  MAX_C   = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0]  ON_C    = CNT_W'(ON_TH);
    localparam logic [CNT_W-1:0]  OFF_C   = CNT_W'(OFF_TH);
    localparam logic [HOLD_W-1:0] HOLD_C  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_M1 = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic {LOW, HIGH} state_t;

    state_t            state, state_nxt;
    logic              ff1, ff2;
    logic [CNT_W-1:0]  cnt;
    logic [HOLD_W-1:0] hold;

    always_ff @(posedge clk) begin
        if (rst) state <= LOW;
        else     state <= state_nxt;
    end

    // Thresholds act on the integrator value before this edge's update.
    always_comb begin
        state_nxt = state;
        case (state)
            LOW:     if (cnt >= ON_C)  state_nxt = HIGH;
            HIGH:    if (cnt <= OFF_C) state_nxt = LOW;
            default: state_nxt = LOW;
        endcase
    end

    assign level      = (state == HIGH);
    assign change_nxt = (state != state_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            ff1        <= 1'b0;
            ff2        <= 1'b0;
            cnt        <= '0;
            hold       <= '0;
            press      <= 1'b0;
            released   <= 1'b0;
            long_press <= 1'b0;
        end else begin
            ff1 <= btn;
            ff2 <= ff1;
            if (ff2 && cnt < MAX_C)       cnt <= cnt + 1'b1;
            else if (!ff2 && cnt != '0)   cnt <= cnt - 1'b1;
            press    <= (state == LOW)  && (state_nxt == HIGH);
            released <= (state == HIGH) && (state_nxt == LOW);
            // Saturating at HOLD_C means the pulse can only fire once per hold.
            if (!level)              hold <= '0;
            else if (hold != HOLD_C) hold <= hold + 1'b1;
            long_press <= level && (hold == HOLD_M1);
        end
    end
endmodule

// Channel array plus the shared any_change strobe. The release pulse port is
// named 'released' because 'release' is a reserved word in SystemVerilog.
module debounce_multi #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 20,
    parameter int MAX_COUNT   = 1048575,
    parameter int ON_TH       = 1000000,
    parameter int OFF_TH      = 500000,
    parameter int HOLD_CYCLES = 50000000,
    parameter int HOLD_W      = 26
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] released,
    output logic [N_CH-1:0] long_press,
    output logic            any_change
);
    logic [N_CH-1:0] change_nxt;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_ch #(
            .CNT_W(CNT_W), .MAX_COUNT(MAX_COUNT), .ON_TH(ON_TH), .OFF_TH(OFF_TH),
            .HOLD_CYCLES(HOLD_CYCLES), .HOLD_W(HOLD_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .btn        (btn[g]),
            .level      (level[g]),
            .press      (press[g]),
            .released   (released[g]),
            .long_press (long_press[g]),
            .change_nxt (change_nxt[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) any_change <= 1'b0;
        else     any_change <= |change_nxt;
    end
endmodule
